// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icode constants, encoder state, instruction payload, byte helper.
// Y86_ENC_HALT_LOCK_EN adds the HALTED encoder state.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT
`ifdef Y86_ENC_HALT_LOCK_EN
        , S_HALTED
`endif
    } enc_state_t;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
    } instr_t;

    // Byte idx of the encoding; valC starts after the register byte when present.
    function automatic logic [7:0] enc_byte(input instr_t i, input logic has_reg,
                                            input logic has_valc, input logic [3:0] idx);
        logic [2:0] k;
        k = has_reg ? 3'(idx - 4'd2) : 3'(idx - 4'd1);
        if (idx == 4'd0)
            return {i.icode, i.ifun};
        else if (has_reg && idx == 4'd1)
            return {i.ra, i.rb};
        else if (has_valc)
            return i.valc[{k, 3'b000} +: 8];
        else
            return 8'h00;
    endfunction

endpackage

// File: rtl/y86_instr_len.sv
// Instruction length/shape decode from icode; shared with Fetch for valP.
module y86_instr_len
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic [3:0] len,
    output logic       valid,
    output logic       has_reg,
    output logic       has_valc
);

    always_comb begin
        len      = 4'd0;
        valid    = 1'b1;
        has_reg  = 1'b0;
        has_valc = 1'b0;
        case (icode)
            I_HALT, I_NOP, I_RET: len = 4'd1;
            I_CMOVXX, I_OPQ, I_PUSHQ, I_POPQ: begin
                len     = 4'd2;
                has_reg = 1'b1;
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                len      = 4'd10;
                has_reg  = 1'b1;
                has_valc = 1'b1;
            end
            I_JXX, I_CALL: begin
                len      = 4'd9;
                has_valc = 1'b1;
            end
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/y86_instr_encoder.sv
// Serializes one decoded Y86-64 instruction per handshake into byte writes.
// Y86_ENC_HALT_LOCK_EN: after halt, stall in HALTED until load_addr.
module y86_instr_encoder
    import y86_pkg::*;
#(
    parameter int unsigned ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_addr,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic [63:0]       valC,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic [ADDR_W-1:0] next_addr,
    output logic              done,
    output logic              err
);

    enc_state_t        state, state_d;
    instr_t            instr_q, instr_d, instr_in;
    logic [3:0]        idx_q, idx_d;
    logic [3:0]        len_q, len_d;
    logic              has_reg_q, has_reg_d;
    logic              has_valc_q, has_valc_d;
    logic [ADDR_W-1:0] next_addr_d, mem_addr_d, base;
    logic              mem_we_d, done_d, err_d;
    logic [7:0]        mem_wdata_d;

    logic [3:0] in_len;
    logic       in_valid_icode, in_has_reg, in_has_valc;

    y86_instr_len u_len (
        .icode    (icode),
        .len      (in_len),
        .valid    (in_valid_icode),
        .has_reg  (in_has_reg),
        .has_valc (in_has_valc)
    );

    assign in_ready = !rst && (state == S_IDLE);

    // Forced register nibbles applied at latch time.
    always_comb begin
        instr_in.icode = icode;
        instr_in.ifun  = ifun;
        instr_in.ra    = (icode == I_IRMOVQ) ? RNONE : rA;
        instr_in.rb    = (icode == I_PUSHQ || icode == I_POPQ) ? RNONE : rB;
        instr_in.valc  = valC;
    end

    always_comb begin
        state_d     = state;
        instr_d     = instr_q;
        idx_d       = idx_q;
        len_d       = len_q;
        has_reg_d   = has_reg_q;
        has_valc_d  = has_valc_q;
        next_addr_d = next_addr;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_we_d    = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        base        = load_addr ? start_addr : next_addr;
        case (state)
            S_IDLE: begin
                next_addr_d = base;
                if (in_valid) begin
                    if (!in_valid_icode) begin
                        err_d = 1'b1;
                    end else begin
                        instr_d     = instr_in;
                        idx_d       = 4'd0;
                        len_d       = in_len;
                        has_reg_d   = in_has_reg;
                        has_valc_d  = in_has_valc;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = base;
                        mem_wdata_d = {icode, ifun};
                        done_d      = (in_len == 4'd1);
                        state_d     = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                next_addr_d = next_addr + ADDR_W'(1);
                if (4'(idx_q + 4'd1) == len_q) begin
`ifdef Y86_ENC_HALT_LOCK_EN
                    state_d = (instr_q.icode == I_HALT) ? S_HALTED : S_IDLE;
`else
                    state_d = S_IDLE;
`endif
                end else begin
                    idx_d       = 4'(idx_q + 4'd1);
                    mem_we_d    = 1'b1;
                    mem_addr_d  = next_addr + ADDR_W'(1);
                    mem_wdata_d = enc_byte(instr_q, has_reg_q, has_valc_q, 4'(idx_q + 4'd1));
                    done_d      = (4'(idx_q + 4'd2) == len_q);
                end
            end
`ifdef Y86_ENC_HALT_LOCK_EN
            S_HALTED: begin
                if (load_addr) begin
                    next_addr_d = start_addr;
                    state_d     = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            instr_q    <= '0;
            idx_q      <= 4'd0;
            len_q      <= 4'd0;
            has_reg_q  <= 1'b0;
            has_valc_q <= 1'b0;
            next_addr  <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 8'h00;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_d;
            instr_q    <= instr_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            has_reg_q  <= has_reg_d;
            has_valc_q <= has_valc_d;
            next_addr  <= next_addr_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

endmodule

// File: doc/y86_instr_encoder.md
# y86_instr_encoder

Sequential instruction encoder/loader for the SEQ Y86-64 processor. It accepts one decoded instruction (icode, ifun, rA, rB, valC) per handshake and serializes it into Y86-64 byte encoding. It writes one byte per cycle into the byte-wide instruction memory that Fetch reads. It is the writer counterpart of the Fetch stage and is used by the program loader and by benches that build instruction images.

## Interface
Parameters:
- ADDR_W, 64, width of instruction-memory byte address (matches PC width)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- load_addr  in  1  load write pointer from start_addr (honoured only in IDLE)
- start_addr  in  ADDR_W  new write pointer value
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder can accept; high only in IDLE and not in reset
- icode  in  4  instruction code
- ifun  in  4  function code
- rA  in  4  register A field
- rB  in  4  register B field
- valC  in  64  constant or destination
- mem_we  out  1  byte write strobe (registered)
- mem_addr  out  ADDR_W  byte address of write (registered)
- mem_wdata  out  8  byte written (registered)
- next_addr  out  ADDR_W  write pointer, i.e. address of the next free byte (valP of the last instruction)
- done  out  1  one-cycle pulse coinciding with the last byte write
- err  out  1  one-cycle pulse, the cycle after an invalid icode is accepted

## Operation
- States: IDLE, EMIT (plus HALTED when Y86_ENC_HALT_LOCK_EN is defined).
- Accept: in_valid && in_ready at a rising edge. Fields are latched, byte index is cleared, and the length is computed.
- Length by icode:
  - 0 (halt), 1 (nop), 9 (ret): 1 byte
  - 2 (cmovXX), 6 (OPq), A (pushq), B (popq): 2 bytes
  - 3 (irmovq), 4 (rmmovq), 5 (mrmovq): 10 bytes
  - 7 (jXX), 8 (call): 9 bytes
  - C–F: invalid
- Byte layout:
  - byte0 = {icode, ifun}
  - register byte {rA, rB} when present
  - valC little-endian: 8 bytes after the register byte for icodes 3/4/5; directly after byte0 for icodes 7/8
- Forced nibbles: irmovq rA is forced to F; pushq/popq rB is forced to F. Other fields pass unchanged; ifun is not range-checked.
- EMIT: each cycle writes byte[idx] at next_addr, then next_addr increments. After the last byte the encoder returns to IDLE.
- Invalid icode: the handshake completes, err pulses, no write occurs, next_addr is unchanged, and the encoder stays in IDLE.
- load_addr together with an accept in the same IDLE cycle: the pointer loads first, so the instruction is written starting at start_addr. load_addr is ignored in EMIT.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is silent.

## Timing
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, next_addr=0, done=0, err=0, state IDLE. in_ready is 0 while rst is high.
- Reset mid-EMIT aborts immediately: no further writes. Bytes already written remain in memory.
- Latency: an accept at edge N gives byte0 on mem_* during cycle N+1; the last byte appears in cycle N+len.
- done is high in cycle N+len. in_ready is high again in cycle N+len+1.
- Throughput: one instruction per len+1 cycles. An invalid icode costs 1 cycle.
- next_addr reads base+k after k bytes have been written; it equals base+len from cycle N+len+1.

## Configuration
- Y86_ENC_HALT_LOCK_EN
  - Defined: after encoding halt (icode 0), the encoder enters HALTED. in_ready stays low until a load_addr pulse, which loads the pointer and returns the encoder to IDLE.
  - Undefined: halt is encoded like nop and the encoder returns to IDLE.

## Structure
- Shared package y86_pkg holds:
  - icode constants (I_HALT … I_POPQ)
  - the no-register constant RNONE=4'hF
  - the state enum
- Sub-module y86_instr_len is combinational: icode → {len[3:0], valid, has_reg, has_valc}. Fetch can reuse it for valP.

## Test plan
- load_addr start_addr=0x100, then irmovq (3,0,rA=2,rB=3,valC=0x0123456789ABCDEF) → bytes 30 F3 EF CD AB 89 67 45 23 01 at 0x100–0x109; done in the 10th write cycle; next_addr=0x10A.
- OPq (6,1,rA=2,rB=3) then back-to-back call (8,0,valC=0x40) → 61 23, then 80 40 00 00 00 00 00 00 00. in_ready is low for exactly 2 and 9 cycles respectively.
- icode=C → err pulses once, mem_we stays 0, next_addr unchanged, in_ready high on the next cycle.
- start_addr=0xFFFF_FFFF_FFFF_FFFF, pushq (A,0,rA=4,rB=7) → A0 at max address, 4F at 0x0; next_addr=0x1.
- rst asserted after the 3rd byte of an rmmovq → mem_we=0 and next_addr=0 immediately; no further writes; in_ready=1 after release.
- With Y86_ENC_HALT_LOCK_EN: halt → 00 written, in_ready stays 0 while in_valid is held high, until load_addr; without the macro, a nop accepted next cycle writes 10.
